// File: rtl/mpt_pkg.sv
// Shared types for the MPT walker pipeline: ROB ids, walker transactions,
// fault causes and the commit-stage response record.
package mpt_pkg;

   // One bit wider than the ROB index so the all-ones "invalid" id never aliases a live entry.
   localparam int unsigned ROB_ID_W = 6;
   localparam int unsigned SPA_W    = 34;

   typedef logic [ROB_ID_W-1:0] rob_id_size_t;

   localparam rob_id_size_t ROB_ID_INVALID = '1;

   typedef enum logic [1:0] {
      ACC_READ  = 2'd0,
      ACC_WRITE = 2'd1,
      ACC_EXEC  = 2'd2,
      ACC_RSVD  = 2'd3
   } mpt_access_e;

   typedef enum logic [1:0] {
      FAULT_NONE       = 2'd0,
      FAULT_ACCESS     = 2'd1,
      FAULT_FORMAT     = 2'd2,
      FAULT_INCOMPLETE = 2'd3
   } mpt_fault_e;

   typedef struct packed {
      rob_id_size_t      id;
      logic [SPA_W-1:0]  spa;
      mpt_access_e       access_type;
      logic              completed;
      logic              format_error;
      logic              access_error;
      logic              walking;
      logic              plb_hit;
   } mptw_transaction_t;

   typedef struct packed {
      rob_id_size_t      id;
      logic [SPA_W-1:0]  spa;
      mpt_access_e       access_type;
      logic              allow;
      mpt_fault_e        fault;
   } mpt_commit_resp_t;

   // Highest-priority cause wins; an invalid id is reported as an incomplete walk.
   function automatic mpt_fault_e mpt_classify(input mptw_transaction_t t);
      if (t.id == ROB_ID_INVALID || !t.completed) return FAULT_INCOMPLETE;
      if (t.format_error)                         return FAULT_FORMAT;
      if (t.access_error)                         return FAULT_ACCESS;
      return FAULT_NONE;
   endfunction

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO with optional fall-through; power-of-two DEPTH.
// full_o is derived from the registered count, so a pop frees space one cycle later.
module fifo_v3 #(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DEPTH        = 4,
   parameter type         dtype        = logic
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic flush_i,
   output logic full_o,
   output logic empty_o,
   input  dtype data_i,
   input  logic push_i,
   output dtype data_o,
   input  logic pop_i
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   dtype             mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no branch can leave one holding its old value (no latch).
      full_o  = (32'(count_q) == DEPTH);
      empty_o = (count_q == '0);
      data_o  = mem_q[rd_ptr_q];
      do_push = 1'b0;
      do_pop  = 1'b0;
      if (FALL_THROUGH && count_q == '0 && push_i) begin
         data_o  = data_i;
         empty_o = 1'b0;
         do_push = !pop_i;
      end else begin
         do_push = push_i && !full_o;
         do_pop  = pop_i && !empty_o;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state updates use <= so every register here samples pre-edge values, independent of statement order.
      if (rst_i || flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/mpt_commit_stage.sv
// Commit stage of the MPT walker: in-order ID check, allow/deny classification,
// response queueing and PLB refill. Perf counters exist only with MPT_COMMIT_PERF_COUNTERS_EN.
module mpt_commit_stage
   import mpt_pkg::*;
#(
   parameter int unsigned PIPELINE_SLAVE_DATA_WIDTH = $bits(mptw_transaction_t),
   parameter int unsigned REORDER_BUFFER_DEPTH      = 32,
   parameter int unsigned RESP_QUEUE_DEPTH          = 4
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  flush_i,
   input  logic                                  commit_stage_slave_valid,
   output logic                                  commit_stage_slave_ready,
   input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  commit_stage_slave_data,
   output logic                                  resp_valid,
   input  logic                                  resp_ready,
   output logic [$bits(mpt_commit_resp_t)-1:0]   resp_data,
   output logic                                  plb_refill_valid,
   input  logic                                  plb_refill_ready,
   output logic [$bits(mptw_transaction_t)-1:0]  plb_refill_data,
   output logic                                  seq_error_o,
   output logic [31:0]                           perf_committed_o,
   output logic [31:0]                           perf_denied_o,
   output logic [31:0]                           perf_refills_o
);

   mptw_transaction_t txn;
   mptw_transaction_t refill_q;
   mpt_commit_resp_t  resp_in;
   mpt_commit_resp_t  resp_out;
   mpt_fault_e        fault;
   rob_id_size_t      expected_id_q;
   rob_id_size_t      expected_id_next;
   logic [ROB_ID_W:0] id_inc;
   logic              id_valid;
   logic              transfer;
   logic              refill_load;
   logic              refill_drain;
   logic              refill_valid_q;
   logic              seq_error_q;
   logic              queue_full;
   logic              queue_empty;

   assign txn          = mptw_transaction_t'(commit_stage_slave_data);
   assign id_valid     = (txn.id != ROB_ID_INVALID);
   assign fault        = mpt_classify(txn);
   assign refill_drain = refill_valid_q && plb_refill_ready;

   // Accepting only when the refill slot is free (or draining now) keeps plb_refill_data stable.
   assign commit_stage_slave_ready = !rst_i && !flush_i && !queue_full &&
                                     (!refill_valid_q || plb_refill_ready);
   assign transfer    = commit_stage_slave_valid && commit_stage_slave_ready;
   assign refill_load = transfer && txn.walking && !txn.plb_hit && (fault == FAULT_NONE);

   assign resp_in = '{id:          txn.id,
                      spa:         txn.spa,
                      access_type: txn.access_type,
                      allow:       (fault == FAULT_NONE),
                      fault:       fault};

   fifo_v3 #(
      .FALL_THROUGH (1'b0),
      .DEPTH        (RESP_QUEUE_DEPTH),
      .dtype        (mpt_commit_resp_t)
   ) u_resp_queue (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .full_o  (queue_full),
      .empty_o (queue_empty),
      .data_i  (resp_in),
      .push_i  (transfer),
      .data_o  (resp_out),
      .pop_i   (resp_valid && resp_ready)
   );

   assign resp_valid = !queue_empty;
   assign resp_data  = resp_valid ? resp_out : '0;

   // Invalid ids are not ROB entries: they neither advance nor check the expected id.
   assign id_inc           = {1'b0, txn.id} + {{ROB_ID_W{1'b0}}, 1'b1};
   assign expected_id_next = (32'(id_inc) >= REORDER_BUFFER_DEPTH) ? '0 : id_inc[ROB_ID_W-1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         expected_id_q <= '0;
         seq_error_q   <= 1'b0;
      end else if (flush_i) begin
         expected_id_q <= '0;
      end else if (transfer && id_valid) begin
         if (txn.id != expected_id_q) seq_error_q <= 1'b1;
         expected_id_q <= expected_id_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         refill_valid_q <= 1'b0;
         refill_q       <= '0;
      end else if (flush_i) begin
         refill_valid_q <= 1'b0;
      end else if (refill_load) begin
         refill_valid_q <= 1'b1;
         refill_q       <= txn;
      end else if (refill_drain) begin
         refill_valid_q <= 1'b0;
      end
   end

   assign plb_refill_valid = refill_valid_q;
   assign plb_refill_data  = refill_q;
   assign seq_error_o      = seq_error_q;

`ifdef MPT_COMMIT_PERF_COUNTERS_EN
   logic [31:0] committed_q;
   logic [31:0] denied_q;
   logic [31:0] refills_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         committed_q <= '0;
         denied_q    <= '0;
         refills_q   <= '0;
      end else begin
         if (transfer && committed_q != '1)                denied_q    <= denied_q;
         if (transfer && committed_q != '1)                committed_q <= committed_q + 32'd1;
         if (transfer && !resp_in.allow && denied_q != '1) denied_q    <= denied_q + 32'd1;
         if (refill_drain && refills_q != '1)              refills_q   <= refills_q + 32'd1;
      end
   end

   assign perf_committed_o = committed_q;
   assign perf_denied_o    = denied_q;
   assign perf_refills_o   = refills_q;
`else
   assign perf_committed_o = '0;
   assign perf_denied_o    = '0;
   assign perf_refills_o   = '0;
`endif

endmodule

// File: tb/tb_mpt_commit_stage.sv
// Directed bench for mpt_commit_stage: a queue-based reference model is checked
// against the DUT every cycle, plus hand-computed literal expectations per scenario.
module tb_mpt_commit_stage;
   import mpt_pkg::*;

   localparam int RQD  = 4;
   localparam int ROBD = 32;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              flush_i;
   logic              sv;
   logic              sr;
   mptw_transaction_t sd;
   logic              resp_valid;
   logic              resp_ready;
   mpt_commit_resp_t  resp_data;
   logic              plb_refill_valid;
   logic              plb_refill_ready;
   mptw_transaction_t plb_refill_data;
   logic              seq_error;
   logic [31:0]       pc;
   logic [31:0]       pd;
   logic [31:0]       pr;

   always #5 clk = ~clk;

   mpt_commit_stage #(
      .REORDER_BUFFER_DEPTH (ROBD),
      .RESP_QUEUE_DEPTH     (RQD)
   ) dut (
      .clk_i                    (clk),
      .rst_i                    (rst_i),
      .flush_i                  (flush_i),
      .commit_stage_slave_valid (sv),
      .commit_stage_slave_ready (sr),
      .commit_stage_slave_data  (sd),
      .resp_valid               (resp_valid),
      .resp_ready               (resp_ready),
      .resp_data                (resp_data),
      .plb_refill_valid         (plb_refill_valid),
      .plb_refill_ready         (plb_refill_ready),
      .plb_refill_data          (plb_refill_data),
      .seq_error_o              (seq_error),
      .perf_committed_o         (pc),
      .perf_denied_o            (pd),
      .perf_refills_o           (pr)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: responses in a queue, one refill slot, plain integer id bookkeeping.
   mpt_commit_resp_t  mq[$];
   bit                m_rf_v   = 0;
   mptw_transaction_t m_rf     = '0;
   bit                m_seq    = 0;
   int                m_exp    = 0;
   int                m_commit = 0;
   int                m_deny   = 0;
   int                m_refill = 0;

   task automatic model_reset();
      mq.delete();
      m_rf_v = 0; m_rf = '0; m_seq = 0; m_exp = 0;
      m_commit = 0; m_deny = 0; m_refill = 0;
   endtask

   task automatic model_commit(input mptw_transaction_t t);
      mpt_commit_resp_t r;
      int  f;
      bit  idv;
      idv = (t.id != rob_id_size_t'(63));
      if (!idv || !t.completed) f = 3;
      else if (t.format_error)  f = 2;
      else if (t.access_error)  f = 1;
      else                      f = 0;
      r.id = t.id; r.spa = t.spa; r.access_type = t.access_type;
      r.fault = mpt_fault_e'(2'(f));
      r.allow = (f == 0);
      mq.push_back(r);
      m_commit++;
      if (f != 0) m_deny++;
      if (idv) begin
         if (int'(t.id) != m_exp) m_seq = 1;
         m_exp = (int'(t.id) + 1 == ROBD) ? 0 : int'(t.id) + 1;
      end
      if (f == 0 && t.walking && !t.plb_hit) begin
         m_rf_v = 1;
         m_rf   = t;
      end
   endtask

   initial begin : compare
      bit exp_ready;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            check("ready_in_reset", sr, 0);
            model_reset();
         end else begin
            exp_ready = (mq.size() < RQD) && (!m_rf_v || plb_refill_ready) && !flush_i;
            check("slave_ready", sr, exp_ready);
            check("resp_valid", resp_valid, mq.size() != 0);
            if (mq.size() != 0) check("resp_data", resp_data, mq[0]);
            check("refill_valid", plb_refill_valid, m_rf_v);
            if (m_rf_v) check("refill_data", plb_refill_data, m_rf);
            check("seq_error", seq_error, m_seq);
`ifdef MPT_COMMIT_PERF_COUNTERS_EN
            check("perf_committed", pc, m_commit);
            check("perf_denied", pd, m_deny);
            check("perf_refills", pr, m_refill);
`else
            check("perf_committed", pc, 0);
            check("perf_denied", pd, 0);
            check("perf_refills", pr, 0);
`endif
            if (m_rf_v && plb_refill_ready) begin
               m_rf_v = 0;
               m_refill++;
            end
            if (flush_i) begin
               mq.delete();
               m_rf_v = 0;
               m_exp  = 0;
            end else begin
               if (mq.size() != 0 && resp_ready) void'(mq.pop_front());
               if (sv && exp_ready) model_commit(sd);
            end
         end
      end
   end

   function automatic mptw_transaction_t mk(input int id, input bit comp, input bit fe,
                                            input bit ae, input bit walk, input bit hit);
      mptw_transaction_t t;
      t.id           = rob_id_size_t'(id);
      t.spa          = 34'(id) * 34'h1000 + 34'h2_0000_0123;
      t.access_type  = mpt_access_e'(2'(id % 3));
      t.completed    = comp;
      t.format_error = fe;
      t.access_error = ae;
      t.walking      = walk;
      t.plb_hit      = hit;
      return t;
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input mptw_transaction_t t);
      bit got;
      got = 0;
      sv  = 1'b1;
      sd  = t;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = sr;
      end
      if (!got) check("send_ready_timeout", sr, 1);
      @(posedge clk);
      #1;
      sv = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; flush_i = 1'b0; sv = 1'b0;
      resp_ready = 1'b1; plb_refill_ready = 1'b1;
      cyc(2);
      @(negedge clk);
      check("rst_ready", sr, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_refill_valid", plb_refill_valid, 0);
      check("rst_seq_error", seq_error, 0);
      check("rst_perf_committed", pc, 0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
   endtask

   mptw_transaction_t t_a;
   mptw_transaction_t t_b;

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; sv = 1'b0; sd = '0;
      resp_ready = 1'b1; plb_refill_ready = 1'b1;
      do_reset();

      // Three in-order clean transfers.
      send(mk(0, 1, 0, 0, 0, 0));
      send(mk(1, 1, 0, 0, 0, 0));
      send(mk(2, 1, 0, 0, 0, 0));
      @(negedge clk);
      check("t1_resp_valid", resp_valid, 1);
      check("t1_id", resp_data.id, 2);
      check("t1_allow", resp_data.allow, 1);
      check("t1_fault", resp_data.fault, 0);
      check("t1_seq", seq_error, 0);
      cyc(1);

      // Format beats access; a faulting walk never refills.
      send(mk(5, 1, 1, 1, 1, 0));
      @(negedge clk);
      check("t2_id", resp_data.id, 5);
      check("t2_fault", resp_data.fault, 2);
      check("t2_allow", resp_data.allow, 0);
      check("t2_no_refill", plb_refill_valid, 0);
`ifdef MPT_COMMIT_PERF_COUNTERS_EN
      check("t2_perf_denied", pd, 1);
      check("t2_perf_committed", pc, 4);
`endif
      cyc(1);

      // Fill the queue with the consumer stalled.
      resp_ready = 1'b0;
      for (int i = 6; i < 10; i++) send(mk(i, 1, 0, 0, 0, 0));
      resp_ready = 1'b1;
      @(negedge clk);
      check("t3_full_ready", sr, 0);
      check("t3_head_id", resp_data.id, 6);
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      check("t3_ready_back", sr, 1);
      check("t3_head_after_pop", resp_data.id, 7);
      cyc(1);
      resp_ready = 1'b1;
      cyc(4);

      // Refill held under back-pressure, then reloaded in the draining cycle.
      plb_refill_ready = 1'b0;
      t_a = mk(10, 1, 0, 0, 1, 0);
      t_b = mk(11, 1, 0, 0, 1, 0);
      send(t_a);
      sv = 1'b1;
      sd = t_b;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_hold_valid", plb_refill_valid, 1);
         check("t4_hold_data", plb_refill_data, t_a);
         check("t4_hold_ready", sr, 0);
         @(posedge clk);
         #1;
      end
      plb_refill_ready = 1'b1;
      @(negedge clk);
      check("t4_ready_with_drain", sr, 1);
      @(posedge clk);
      #1;
      sv = 1'b0;
      @(negedge clk);
      check("t4_reload_valid", plb_refill_valid, 1);
      check("t4_reload_data", plb_refill_data, t_b);
`ifdef MPT_COMMIT_PERF_COUNTERS_EN
      check("t4_perf_refills", pr, 1);
`endif
      cyc(1);
      @(negedge clk);
      check("t4_drained", plb_refill_valid, 0);
      cyc(1);

      // Out-of-order id sets the sticky error; wrap afterwards.
      do_reset();
      send(mk(0, 1, 0, 0, 0, 0));
      @(negedge clk);
      check("t5_seq_clean", seq_error, 0);
      cyc(1);
      send(mk(2, 1, 0, 0, 0, 0));
      @(negedge clk);
      check("t5_seq_set", seq_error, 1);
      cyc(1);
      send(mk(31, 1, 0, 0, 0, 0));
      send(mk(0, 1, 0, 0, 0, 0));
      cyc(1);

      // Full ROB wrap with an invalid id in the middle: no sequence error.
      do_reset();
      for (int i = 0; i < 4; i++) send(mk(i, 1, 0, 0, 0, 0));
      send(mk(63, 1, 0, 0, 1, 0));
      @(negedge clk);
      check("t5_invalid_fault", resp_data.fault, 3);
      check("t5_invalid_allow", resp_data.allow, 0);
      check("t5_invalid_no_refill", plb_refill_valid, 0);
      cyc(1);
      for (int i = 4; i < 32; i++) send(mk(i, 1, 0, 0, 0, 0));
      send(mk(0, 1, 0, 0, 0, 0));
      @(negedge clk);
      check("t5_wrap_no_error", seq_error, 0);
      check("t5_wrap_id", resp_data.id, 0);
      cyc(1);

      // Flush with two queued responses and a pending refill.
      resp_ready = 1'b0;
      plb_refill_ready = 1'b0;
      send(mk(1, 1, 0, 0, 0, 0));
      send(mk(2, 1, 0, 0, 1, 0));
      flush_i = 1'b1;
      sv = 1'b1;
      sd = mk(3, 1, 0, 0, 0, 0);
      @(negedge clk);
      check("t6_flush_ready", sr, 0);
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      sv = 1'b0;
      @(negedge clk);
      check("t6_resp_valid", resp_valid, 0);
      check("t6_refill_valid", plb_refill_valid, 0);
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      plb_refill_ready = 1'b1;
      send(mk(0, 1, 0, 0, 0, 0));
      @(negedge clk);
      check("t6_seq_after_flush", seq_error, 0);
      check("t6_id", resp_data.id, 0);
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mpt_commit_stage.md
# mpt_commit_stage

Commit stage of the MPT walker pipeline: the consumer of the retire stage's in-order commit port. It accepts completed transactions from the ROB, checks ID ordering, classifies each into an allow/deny response with a fault cause, queues the responses for the external requester, and emits PLB refill requests for walked translations.

## Interface
- PIPELINE_SLAVE_DATA_WIDTH, default $bits(mptw_transaction_t): width of the retire-side data bus.
- REORDER_BUFFER_DEPTH, default 32: ROB depth; the expected-ID counter wraps at this value.
- RESP_QUEUE_DEPTH, default 4: response queue entries, power of two ≥ 2.
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  drops queued responses and pending refill; resets the expected ID.
- commit_stage_slave_valid  in  1  retire stage presents a completed transaction.
- commit_stage_slave_ready  out  1  transaction accepted this cycle.
- commit_stage_slave_data  in  PIPELINE_SLAVE_DATA_WIDTH  packed mptw_transaction_t.
- resp_valid / resp_ready  out / in  1  response handshake to the requester.
- resp_data  out  $bits(mpt_commit_resp_t)  {id, spa, access_type, allow, fault}.
- plb_refill_valid / plb_refill_ready  out / in  1  refill handshake to the PLB.
- plb_refill_data  out  $bits(mptw_transaction_t)  transaction to install.
- seq_error_o  out  1  sticky; set on an out-of-order ID.
- perf_committed_o, perf_denied_o, perf_refills_o  out  32 each  performance counters.

## Operation
- Accept: ready = !resp_queue_full && (!plb_refill_valid || plb_refill_ready) && !flush_i. A transfer occurs when valid && ready.
- Fault classification on the transfer, with priority:
  - !completed → INCOMPLETE (3).
  - format_error → FORMAT (2).
  - access_error → ACCESS (1).
  - otherwise NONE (0).
- allow = valid && (fault == NONE).
- Every transfer pushes exactly one response.
- Refill: on a transfer with walking && !plb_hit && fault == NONE, load the refill register and set plb_refill_valid. It is held until plb_refill_ready. A new load in the same cycle as a drain is permitted.
- Ordering check:
  - expected_id_q starts at 0.
  - On each transfer, if id != expected_id_q, set seq_error_o. It clears only on rst_i.
  - The transaction still commits normally.
  - expected_id_q then advances from the received id + 1, wrapping to 0 at REORDER_BUFFER_DEPTH.
- ID all-ones is invalid: it produces a response with fault INCOMPLETE and allow = 0, never a refill, and does not advance expected_id_q.
- Flush: empties the response queue, clears plb_refill_valid, sets expected_id_q = 0. No transfer occurs in the flush cycle.

## Timing
- Reset: all outputs are 0, including commit_stage_slave_ready. The queue is empty, expected_id_q = 0, and all counters are 0. A reset mid-operation discards queued responses and the pending refill.
- Latency: a transfer in cycle N gives resp_valid in cycle N+1 (non-fall-through queue). plb_refill_valid is also registered and asserts in N+1.
- resp_data and plb_refill_data are stable while valid && !ready.
- Full queue: ready = 0. A pop in the same cycle does not re-enable ready until the following cycle (registered full flag).
- One transfer per cycle; sustained throughput is 1/cycle when both consumers are always ready.

## Configuration
- MPT_COMMIT_PERF_COUNTERS_EN defined: three 32-bit saturating counters, cleared only by rst_i.
  - perf_committed_o increments on every transfer.
  - perf_denied_o increments on transfers with allow = 0.
  - perf_refills_o increments on plb_refill handshakes.
- Macro not defined: the counters are not instantiated and all perf_* outputs are tied to 0.

## Structure
- mpt_pkg holds:
  - mpt_commit_resp_t.
  - mpt_fault_e (NONE/ACCESS/FORMAT/INCOMPLETE, 2 bits).
  - The existing mptw_transaction_t and rob_id_size_t.
- Sub-module: the response queue is a fifo_v3 instance with FALL_THROUGH = 0, dtype mpt_commit_resp_t, and flush_i wired to flush_i.
- The refill register, expected-ID counter and counters are local logic.

## Test plan
- Reset release, then three transfers with ids 0, 1, 2, all completed and no errors, resp_ready = 1 → three responses, allow = 1 and fault = 0, each one cycle after its transfer; seq_error_o = 0.
- Transfer with id 5, completed, format_error = 1, access_error = 1 → fault = 2, allow = 0, no refill; perf_denied_o = 1 when the macro is defined.
- resp_ready = 0 while pushing 4 transfers → commit_stage_slave_ready = 0 from the cycle after the 4th push; after draining one entry, ready returns the next cycle.
- Walked transaction (walking = 1, plb_hit = 0) with plb_refill_ready = 0 for 3 cycles → refill data held stable; ready = 0; a second transfer is accepted in the cycle refill_ready rises.
- Ids 0 then 2 → seq_error_o = 1 from the second transfer onward; expected becomes 3. Then id 31 followed by id 0 → no new error (wrap).
- flush_i with 2 queued responses and a pending refill → next cycle resp_valid = 0, plb_refill_valid = 0; a following id 0 produces no sequence error.
